// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit signal bundle for hazard_scoreboard.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface hazard_scoreboard_if #(
    parameter int FWD_STAGES = 2,
    parameter int FSW        = $clog2(FWD_STAGES + 1)
);
    logic [4:0]              Rs1D, Rs2D, RdD;
    logic                    RegWriteD, LongD;
    logic [4:0]              Rs1E, Rs2E, RdE;
    logic                    RegWriteE;
    logic [1:0]              ResultSrcE;
    logic                    LongIssueE;
    logic                    mispredictE;
    logic                    BusyE;
    logic [5*FWD_STAGES-1:0] FwdRd;
    logic [FWD_STAGES-1:0]   FwdWe;
    logic                    LongDone;
    logic [4:0]              LongRd;

    logic                    StallF, StallD, FlushD, StallE, FlushE, FlushM;
    logic [FSW-1:0]          ForwardAE, ForwardBE;
    logic                    LongFull;
    logic [31:0]             SbPending;
    logic [31:0]             PerfStallCnt, PerfFlushCnt;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, LongD, Rs1E, Rs2E, RdE, RegWriteE,
               ResultSrcE, LongIssueE, mispredictE, BusyE, FwdRd, FwdWe, LongDone, LongRd,
        input  StallF, StallD, FlushD, StallE, FlushE, FlushM, ForwardAE, ForwardBE,
               LongFull, SbPending, PerfStallCnt, PerfFlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, LongD, Rs1E, Rs2E, RdE, RegWriteE,
               ResultSrcE, LongIssueE, mispredictE, BusyE, FwdRd, FwdWe, LongDone, LongRd,
        output StallF, StallD, FlushD, StallE, FlushE, FlushM, ForwardAE, ForwardBE,
               LongFull, SbPending, PerfStallCnt, PerfFlushCnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard controller: N-source forwarding, load-use shadow and long-latency register scoreboard.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int  FWD_STAGES = 2,
    parameter int  LOAD_LAT   = 1,
    parameter int  MAX_LONG   = 2,
    localparam int FSW        = $clog2(FWD_STAGES + 1)
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave hif
);
    localparam int CW = $clog2(MAX_LONG + 1);

    function automatic logic srcHit(input logic [4:0] src, input logic [4:0] rd);
        return (src != 5'd0) && (src == rd);
    endfunction

    logic [FSW-1:0] fwdA, fwdB;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fwdA = '0;
        fwdB = '0;
        // Walk oldest to youngest so the youngest matching source is assigned last and wins.
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hif.FwdWe[k] && srcHit(hif.Rs1E, hif.FwdRd[5*k +: 5])) fwdA = FSW'(k + 1);
            if (hif.FwdWe[k] && srcHit(hif.Rs2E, hif.FwdRd[5*k +: 5])) fwdB = FSW'(k + 1);
        end
    end

    logic loadE, shadowHit, ldStall;
    assign loadE = (hif.ResultSrcE == 2'b01) && hif.RegWriteE;

    generate
        if (LOAD_LAT > 1) begin : g_shadow
            logic [LOAD_LAT-1:1] ldv;
            logic [4:0]          ldrd [1:LOAD_LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: sequential state is updated with non-blocking assignments only.
                if (!rst_n) begin
                    ldv <= '0;
                end else begin
                    ldv[1] <= loadE && !hif.BusyE;
                    for (int j = 2; j < LOAD_LAT; j++) ldv[j] <= ldv[j-1];
                end
            end

            // NOTE: the destination payload is not reset; ldv qualifies every use of it.
            always_ff @(posedge clk) begin
                ldrd[1] <= hif.RdE;
                for (int j = 2; j < LOAD_LAT; j++) ldrd[j] <= ldrd[j-1];
            end

            always_comb begin
                shadowHit = 1'b0;
                for (int j = 1; j < LOAD_LAT; j++) begin
                    if (ldv[j] && (srcHit(hif.Rs1D, ldrd[j]) || srcHit(hif.Rs2D, ldrd[j])))
                        shadowHit = 1'b1;
                end
            end
        end else begin : g_noShadow
            assign shadowHit = 1'b0;
        end
    endgenerate

    assign ldStall = (loadE && (srcHit(hif.Rs1D, hif.RdE) || srcHit(hif.Rs2D, hif.RdE))) || shadowHit;

    logic [31:0]   pend, pendNext;
    logic [CW-1:0] cnt;
    logic          sbSet, sbClr, longFull, sbStall;

    assign sbSet = hif.LongIssueE && !hif.BusyE && (hif.RdE != 5'd0);
    assign sbClr = hif.LongDone && pend[hif.LongRd];

    // Set is applied after clear so a same-register issue and writeback leaves the bit pending.
    always_comb begin
        pendNext = pend;
        if (sbClr) pendNext[hif.LongRd] = 1'b0;
        if (sbSet) pendNext[hif.RdE]    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pendNext;
            cnt  <= cnt + CW'(sbSet) - CW'(sbClr);
        end
    end

    assign longFull = (cnt == CW'(MAX_LONG));

    assign sbStall = (srcHit(hif.Rs1D, hif.Rs1D) && pend[hif.Rs1D])
                   || (srcHit(hif.Rs2D, hif.Rs2D) && pend[hif.Rs2D])
                   || (hif.RegWriteD && (hif.RdD != 5'd0) && pend[hif.RdD])
                   || (hif.LongIssueE && (hif.RdE != 5'd0)
                       && (srcHit(hif.Rs1D, hif.RdE) || srcHit(hif.Rs2D, hif.RdE) || (hif.RdD == hif.RdE)))
                   || (hif.LongD && longFull);

    logic decodeHazard, stallD, flushD;
    assign decodeHazard = ldStall || sbStall;
    assign stallD       = hif.BusyE || (!hif.mispredictE && decodeHazard);
    assign flushD       = hif.mispredictE && !hif.BusyE;

    assign hif.StallF    = stallD;
    assign hif.StallD    = stallD;
    assign hif.FlushD    = flushD;
    assign hif.StallE    = hif.BusyE;
    assign hif.FlushE    = !hif.BusyE && (hif.mispredictE || decodeHazard);
    assign hif.FlushM    = hif.BusyE;
    assign hif.ForwardAE = fwdA;
    assign hif.ForwardBE = fwdB;
    assign hif.LongFull  = longFull;
    assign hif.SbPending = pend;

`ifdef HAZARD_PERF_EN
    logic [31:0] perfStall, perfFlush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfStall <= '0;
            perfFlush <= '0;
        end else begin
            if (stallD && (perfStall != '1)) perfStall <= perfStall + 32'd1;
            if (flushD && (perfFlush != '1)) perfFlush <= perfFlush + 32'd1;
        end
    end

    assign hif.PerfStallCnt = perfStall;
    assign hif.PerfFlushCnt = perfFlush;
`else
    assign hif.PerfStallCnt = '0;
    assign hif.PerfFlushCnt = '0;
`endif

    // A redirect while the E stage is busy has no defined meaning.
    assert property (@(posedge clk) disable iff (!rst_n) !(hif.mispredictE && hif.BusyE));
    // LongFull stalls D, so an issue into a full scoreboard cannot happen without a retirement.
    assert property (@(posedge clk) disable iff (!rst_n) !(sbSet && !sbClr && longFull));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench for hazard_scoreboard: directed test-plan cases, then randomized traffic.
module tb_hazard_scoreboard;
    localparam int FWD  = 2;
    localparam int LLAT = 3;
    localparam int MAXL = 2;
    localparam int FSW  = $clog2(FWD + 1);
`ifdef HAZARD_PERF_EN
    localparam int EXP_PERF_S = 5;
    localparam int EXP_PERF_F = 2;
`else
    localparam int EXP_PERF_S = 0;
    localparam int EXP_PERF_F = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.FWD_STAGES(FWD)) hif ();
    hazard_scoreboard #(.FWD_STAGES(FWD), .LOAD_LAT(LLAT), .MAX_LONG(MAXL)) dut (
        .clk(clk), .rst_n(rst_n), .hif(hif)
    );

    typedef struct packed {
        logic           stallF, stallD, flushD, stallE, flushE, flushM;
        logic [FSW-1:0] fwdA, fwdB;
        logic           longFull;
        logic [31:0]    pend, perfStall, perfFlush;
    } obs_t;

    typedef struct { logic [4:0] rd; int age; } ld_t;

    obs_t   expQ[$];
    ld_t    loads[$];
    bit     pendM[32];
    int     cntM;
    longint perfS, perfF;
    int     nTests = 0;
    int     nFail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit readsReg(input logic [4:0] r);
        return (r != 5'd0) && ((r == hif.Rs1D) || (r == hif.Rs2D));
    endfunction

    task automatic modelReset();
        loads.delete();
        for (int r = 0; r < 32; r++) pendM[r] = 1'b0;
        cntM  = 0;
        perfS = 0;
        perfF = 0;
    endtask

    function automatic obs_t predict();
        obs_t o;
        bit   found, loadE, ldS, sbS, hz;
        o     = '0;
        found = 1'b0;
        for (int k = 0; k < FWD; k++)
            if (!found && hif.FwdWe[k] && hif.Rs1E != 0 && hif.FwdRd[5*k +: 5] == hif.Rs1E) begin
                o.fwdA = FSW'(k + 1);
                found  = 1'b1;
            end
        found = 1'b0;
        for (int k = 0; k < FWD; k++)
            if (!found && hif.FwdWe[k] && hif.Rs2E != 0 && hif.FwdRd[5*k +: 5] == hif.Rs2E) begin
                o.fwdB = FSW'(k + 1);
                found  = 1'b1;
            end
        loadE = (hif.ResultSrcE == 2'b01) && hif.RegWriteE;
        ldS   = loadE && readsReg(hif.RdE);
        foreach (loads[i]) if (readsReg(loads[i].rd)) ldS = 1'b1;
        sbS = 1'b0;
        for (int r = 1; r < 32; r++) if (pendM[r] && readsReg(5'(r))) sbS = 1'b1;
        if (hif.RegWriteD && hif.RdD != 0 && pendM[hif.RdD]) sbS = 1'b1;
        if (hif.LongIssueE && hif.RdE != 0 && (readsReg(hif.RdE) || hif.RdD == hif.RdE)) sbS = 1'b1;
        if (hif.LongD && cntM == MAXL) sbS = 1'b1;
        hz         = ldS || sbS;
        o.stallD   = hif.BusyE || (!hif.mispredictE && hz);
        o.stallF   = o.stallD;
        o.flushD   = hif.mispredictE && !hif.BusyE;
        o.stallE   = hif.BusyE;
        o.flushE   = !hif.BusyE && (hif.mispredictE || hz);
        o.flushM   = hif.BusyE;
        o.longFull = (cntM == MAXL);
        for (int r = 0; r < 32; r++) o.pend[r] = pendM[r];
`ifdef HAZARD_PERF_EN
        o.perfStall = perfS[31:0];
        o.perfFlush = perfF[31:0];
`endif
        return o;
    endfunction

    task automatic advance(input obs_t o);
        ld_t aged[$];
        bit  set, clr;
        foreach (loads[i]) if (loads[i].age + 1 < LLAT) aged.push_back('{loads[i].rd, loads[i].age + 1});
        if (hif.ResultSrcE == 2'b01 && hif.RegWriteE && !hif.BusyE && LLAT > 1)
            aged.push_back('{hif.RdE, 1});
        loads = aged;
        clr = hif.LongDone && pendM[hif.LongRd];
        set = hif.LongIssueE && !hif.BusyE && hif.RdE != 0;
        if (clr) pendM[hif.LongRd] = 1'b0;
        if (set) pendM[hif.RdE] = 1'b1;
        cntM = cntM + int'(set) - int'(clr);
        if (o.stallD && perfS < 64'hFFFF_FFFF) perfS++;
        if (o.flushD && perfF < 64'hFFFF_FFFF) perfF++;
    endtask

    task automatic step();
        obs_t o;
        if (!rst_n) modelReset();
        o = predict();
        expQ.push_back(o);
        if (rst_n) advance(o);
    endtask

    task automatic idle();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.RdD = 0; hif.RegWriteD = 0; hif.LongD = 0;
        hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0; hif.RegWriteE = 0; hif.ResultSrcE = 0;
        hif.LongIssueE = 0; hif.mispredictE = 0; hif.BusyE = 0;
        hif.FwdRd = 0; hif.FwdWe = 0; hif.LongDone = 0; hif.LongRd = 0;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.stallF    = hif.StallF;    o.stallD    = hif.StallD;    o.flushD = hif.FlushD;
        o.stallE    = hif.StallE;    o.flushE    = hif.FlushE;    o.flushM = hif.FlushM;
        o.fwdA      = hif.ForwardAE; o.fwdB      = hif.ForwardBE; o.longFull = hif.LongFull;
        o.pend      = hif.SbPending; o.perfStall = hif.PerfStallCnt;
        o.perfFlush = hif.PerfFlushCnt;
        return o;
    endfunction

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                obs_t e;
                e = expQ.pop_front();
                check("cycle", sample(), e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        modelReset();
        @(negedge clk); step(); #3;
        check("reset_all_zero", sample(), 0);
        @(negedge clk); rst_n = 1'b1; idle(); step();

        // Forwarding priority
        @(negedge clk); idle(); hif.FwdWe = 2'b11; hif.FwdRd = {5'd5, 5'd5}; hif.Rs1E = 5; step(); #3;
        check("fwd_m_wins", hif.ForwardAE, 1);
        @(negedge clk); idle(); hif.FwdWe = 2'b11; hif.FwdRd = {5'd5, 5'd5}; hif.Rs1E = 0; step(); #3;
        check("fwd_x0", hif.ForwardAE, 0);

        // Load-use shadow of three bubbles
        @(negedge clk); idle(); hif.ResultSrcE = 2'b01; hif.RegWriteE = 1; hif.RdE = 7; hif.Rs1D = 7; step(); #3;
        check("ld_stall_0", {hif.StallD, hif.FlushE}, 2'b11);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); idle(); hif.Rs1D = 7; step(); #3;
            check($sformatf("ld_stall_%0d", i), {hif.StallD, hif.FlushE}, (i < 3) ? 2'b11 : 2'b00);
        end

        // Scoreboard RAW on x9
        @(negedge clk); idle(); hif.LongIssueE = 1; hif.RdE = 9; step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); hif.Rs2D = 9; step(); #3;
            check("sb_raw_hold", hif.StallD, 1);
        end
        @(negedge clk); idle(); hif.Rs2D = 9; hif.LongDone = 1; hif.LongRd = 9; step(); #3;
        check("sb_done_cycle", hif.StallD, 1);
        @(negedge clk); idle(); hif.Rs2D = 9; step(); #3;
        check("sb_release", hif.StallD, 0);
        @(negedge clk); idle(); hif.LongIssueE = 1; hif.RdE = 9; step();
        @(negedge clk); idle(); hif.LongIssueE = 1; hif.RdE = 9; hif.LongDone = 1; hif.LongRd = 9; step();
        @(negedge clk); idle(); step(); #3;
        check("sb_set_wins", hif.SbPending[9], 1);
        @(negedge clk); idle(); hif.LongDone = 1; hif.LongRd = 9; step();

        // Capacity
        @(negedge clk); idle(); hif.LongIssueE = 1; hif.RdE = 3; step();
        @(negedge clk); idle(); hif.LongIssueE = 1; hif.RdE = 4; step();
        @(negedge clk); idle(); hif.LongD = 1; step(); #3;
        check("cap_full", {hif.LongFull, hif.StallD}, 2'b11);
        @(negedge clk); idle(); hif.LongD = 1; hif.LongDone = 1; hif.LongRd = 3; step(); #3;
        check("cap_done_cycle", hif.StallD, 1);
        @(negedge clk); idle(); hif.LongD = 1; step(); #3;
        check("cap_release", {hif.LongFull, hif.StallD}, 2'b00);
        @(negedge clk); idle(); hif.LongDone = 1; hif.LongRd = 4; step();

        // Priority: mispredict over load stall, busy over everything
        @(negedge clk); idle(); hif.ResultSrcE = 2'b01; hif.RegWriteE = 1; hif.RdE = 7; hif.Rs1D = 7;
        hif.mispredictE = 1; step(); #3;
        check("mispredict_over_ld", {hif.StallD, hif.FlushD, hif.FlushE}, 3'b011);
        @(negedge clk); idle(); hif.BusyE = 1; step(); #3;
        check("busy", {hif.StallF, hif.StallD, hif.StallE, hif.FlushM, hif.FlushE}, 5'b11110);

        // Performance counters
        @(negedge clk); rst_n = 1'b0; idle(); step();
        @(negedge clk); rst_n = 1'b1; idle(); step();
        repeat (5) begin @(negedge clk); idle(); hif.BusyE = 1; step(); end
        repeat (2) begin @(negedge clk); idle(); hif.mispredictE = 1; step(); end
        @(negedge clk); idle(); step(); #3;
        check("perf_stall", hif.PerfStallCnt, EXP_PERF_S);
        check("perf_flush", hif.PerfFlushCnt, EXP_PERF_F);
        @(negedge clk); idle(); hif.BusyE = 1; step();
        @(negedge clk); rst_n = 1'b0; idle(); step(); #1;
        check("perf_reset", {hif.PerfStallCnt, hif.PerfFlushCnt}, 0);
        @(negedge clk); rst_n = 1'b1; idle(); step();

        // Randomized traffic on a narrow register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            bit clr, clrSame;
            @(negedge clk);
            rst_n          = (n != 1500);
            hif.Rs1D       = 5'($urandom_range(0, 7));
            hif.Rs2D       = 5'($urandom_range(0, 7));
            hif.RdD        = 5'($urandom_range(0, 7));
            hif.RegWriteD  = 1'($urandom_range(0, 1));
            hif.LongD      = ($urandom_range(0, 3) == 0);
            hif.Rs1E       = 5'($urandom_range(0, 7));
            hif.Rs2E       = 5'($urandom_range(0, 7));
            hif.RdE        = 5'($urandom_range(0, 7));
            hif.RegWriteE  = 1'($urandom_range(0, 1));
            hif.ResultSrcE = 2'($urandom_range(0, 3));
            hif.BusyE      = ($urandom_range(0, 7) == 0);
            hif.mispredictE = !hif.BusyE && ($urandom_range(0, 9) == 0);
            hif.FwdRd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            hif.FwdWe      = 2'($urandom_range(0, 3));
            hif.LongDone   = ($urandom_range(0, 2) == 0);
            hif.LongRd     = 5'($urandom_range(0, 7));
            hif.LongIssueE = ($urandom_range(0, 3) == 0);
            clr     = hif.LongDone && pendM[hif.LongRd];
            clrSame = clr && (hif.LongRd == hif.RdE);
            if (hif.LongIssueE && !hif.BusyE && hif.RdE != 0)
                if ((pendM[hif.RdE] && !clrSame) || (cntM == MAXL && !clr)) hif.LongIssueE = 0;
            step();
        end

        @(negedge clk); rst_n = 1'b1; idle();
        repeat (3) @(negedge clk);
        #4;
        check("queue_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
